// File: rtl/seq10010_window_ctrl_if.sv
// Bundle of host, serial-source and detector signals around the 10010 window sequencer.
// The sequencer connects through the slave modport; the host/source/detector side uses master.
interface seq10010_window_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int HIT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             busy;
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             det_clr;
    logic             det_en;
    logic             det_in;
    logic             det_hit;
    logic             done;
    logic [HIT_W-1:0] hit_cnt;
    logic             overflow;
    logic             ack;

    modport master (
        output start, win_len, bit_valid, bit_in, det_hit, ack,
        input  busy, bit_ready, det_clr, det_en, det_in, done, hit_cnt, overflow
    );

    modport slave (
        input  start, win_len, bit_valid, bit_in, det_hit, ack,
        output busy, bit_ready, det_clr, det_en, det_in, done, hit_cnt, overflow
    );
endinterface

// File: rtl/seq10010_window_ctrl.sv
// Window sequencer for a 10010 Moore detector: clears it, feeds win_len serial bits,
// counts hits (saturating, with sticky overflow) and holds the result until acknowledged.
module seq10010_window_ctrl #(
    parameter int CNT_W = 8,
    parameter int HIT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    seq10010_window_ctrl_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [HIT_W-1:0] HIT_ZERO = {HIT_W{1'b0}};
    localparam logic [HIT_W-1:0] HIT_ONE  = {{(HIT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] rem_r;
    logic [HIT_W-1:0] hit_cnt_r;
    logic             overflow_r;
    logic             adv_r;

    logic             accept_s;
    logic             count_s;
    logic             sat_s;

    // A hit is only counted in the cycle right after the detector advanced,
    // so a stalled stream cannot count the same Moore output twice.
    assign accept_s = (state_r == ST_RUN) & bus.bit_valid;
    assign count_s  = adv_r & bus.det_hit & ((state_r == ST_RUN) | (state_r == ST_DRAIN));
    assign sat_s    = &hit_cnt_r;

    assign bus.busy      = (state_r == ST_CLR) | (state_r == ST_RUN) | (state_r == ST_DRAIN);
    assign bus.bit_ready = (state_r == ST_RUN);
    assign bus.det_clr   = (state_r == ST_CLR);
    assign bus.det_en    = accept_s;
    assign bus.det_in    = bus.bit_in;
    assign bus.done      = (state_r == ST_DONE);
    assign bus.hit_cnt   = hit_cnt_r;
    assign bus.overflow  = overflow_r;

    // Window FSM, remaining-bit counter and saturating hit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            rem_r      <= CNT_ZERO;
            hit_cnt_r  <= HIT_ZERO;
            overflow_r <= 1'b0;
            adv_r      <= 1'b0;
        end else begin
            adv_r <= accept_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.win_len != CNT_ZERO) begin
                            rem_r   <= bus.win_len;
                            state_r <= ST_CLR;
                        end else begin
                            hit_cnt_r  <= HIT_ZERO;
                            overflow_r <= 1'b0;
                            state_r    <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    hit_cnt_r  <= HIT_ZERO;
                    overflow_r <= 1'b0;
                    adv_r      <= 1'b0;
                    state_r    <= ST_RUN;
                end
                ST_RUN, ST_DRAIN: begin
                    if (count_s) begin
                        if (sat_s) begin
                            overflow_r <= 1'b1;
                        end else begin
                            hit_cnt_r <= hit_cnt_r + HIT_ONE;
                        end
                    end else begin
                        hit_cnt_r <= hit_cnt_r;
                    end
                    if (state_r == ST_DRAIN) begin
                        state_r <= ST_DONE;
                    end else if (accept_s) begin
                        rem_r <= rem_r - CNT_ONE;
                        if (rem_r == CNT_ONE) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (bus.ack) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq10010_window_ctrl.sv
// Self-checking bench for seq10010_window_ctrl with a behavioural 10010 detector
// and a scoreboard of expected window results.
module tb_seq10010_window_ctrl;

    localparam int CNT_W = 8;
    localparam int HIT_W = 2;

    logic clk;
    logic rst;

    seq10010_window_ctrl_if #(.CNT_W(CNT_W), .HIT_W(HIT_W)) bus ();

    seq10010_window_ctrl #(.CNT_W(CNT_W), .HIT_W(HIT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          len;
        logic [15:0] bits;
        bit          gap;
        bit          disturb;
        int          hits;
        bit          ovf;
    } vec_t;

    typedef struct {
        int hits;
        int ovf;
        int en;
        int clr;
        int lat;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_cnt;
    int   clr_cnt;
    logic [2:0] ds;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 10010 Moore detector with overlap; state = length of matched prefix.
    function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    det_next = b ? 3'd1 : 3'd0;
            3'd1:    det_next = b ? 3'd1 : 3'd2;
            3'd2:    det_next = b ? 3'd1 : 3'd3;
            3'd3:    det_next = b ? 3'd4 : 3'd0;
            3'd4:    det_next = b ? 3'd1 : 3'd5;
            3'd5:    det_next = b ? 3'd1 : 3'd3;
            default: det_next = 3'd0;
        endcase
    endfunction

    // Detector model state, driven by the DUT's clear/enable.
    always @(posedge clk or negedge rst) begin
        if (!rst)             ds <= 3'd0;
        else if (bus.det_clr) ds <= 3'd0;
        else if (bus.det_en)  ds <= det_next(ds, bus.det_in);
    end
    assign bus.det_hit = (ds == 3'd5);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare a finished window against the scoreboard, then hold and acknowledge.
    task automatic finish_window(input int lat);
        exp_t e;
        e = sb_q.pop_front();
        chk("hit_cnt", 32'(bus.hit_cnt), 32'(e.hits));
        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
        chk("det_en_pulses", 32'(en_cnt), 32'(e.en));
        chk("det_clr_pulses", 32'(clr_cnt), 32'(e.clr));
        if (e.lat >= 0) chk("done_latency", 32'(lat), 32'(e.lat));
        bus.bit_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("done_held", 32'(bus.done), 32'd1);
            chk("hit_cnt_frozen", 32'(bus.hit_cnt), 32'(e.hits));
        end
        @(negedge clk);
        bus.ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ack = 1'b0;
        #1;
        chk("done_after_ack", 32'(bus.done), 32'd0);
        chk("busy_after_ack", 32'(bus.busy), 32'd0);
        chk("hit_cnt_in_idle", 32'(bus.hit_cnt), 32'(e.hits));
    endtask

    task automatic run_window(input vec_t v);
        exp_t e;
        int   n;
        int   idx;
        int   gap_left;
        bit   seen;
        @(negedge clk);
        en_cnt        = 0;
        clr_cnt       = 0;
        bus.start     = 1'b1;
        bus.win_len   = CNT_W'(v.len);
        bus.bit_valid = 1'b0;
        e.hits = v.hits;
        e.ovf  = int'(v.ovf);
        e.en   = v.len;
        e.clr  = (v.len != 0) ? 1 : 0;
        e.lat  = v.gap ? -1 : ((v.len == 0) ? 1 : v.len + 3);
        sb_q.push_back(e);
        @(posedge clk);
        n = 0; idx = 0; gap_left = 0; seen = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.ack       = 1'b0;
            bus.bit_valid = 1'b0;
            bus.bit_in    = 1'($urandom_range(0, 1));
            if (bus.bit_ready) begin
                if (v.disturb) begin
                    bus.start   = 1'b1;
                    bus.win_len = 8'd3;
                    bus.ack     = 1'b1;
                end
                if (gap_left > 0) begin
                    gap_left--;
                end else if (idx < v.len) begin
                    bus.bit_valid = 1'b1;
                    bus.bit_in    = v.bits[v.len - 1 - idx];
                    idx++;
                    if (v.gap) gap_left = $urandom_range(1, 3);
                end
            end else if (!bus.done) begin
                bus.bit_valid = 1'($urandom_range(0, 1));
            end
            #1;
            if (bus.det_en)  en_cnt++;
            if (bus.det_clr) clr_cnt++;
            if (bus.done) begin
                seen = 1;
                finish_window(n + 1);
            end else begin
                @(posedge clk);
                n++;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL window_timeout: done never rose for win_len %0d", v.len);
            void'(sb_q.pop_front());
        end
    endtask

    initial begin
        vecs[0] = '{5,  16'b10010,            1'b0, 1'b0, 1, 1'b0};
        vecs[1] = '{8,  16'b10010010,         1'b1, 1'b0, 2, 1'b0};
        vecs[2] = '{16, 16'b1001001001001001, 1'b0, 1'b0, 3, 1'b1};
        vecs[3] = '{11, 16'b10010010010,      1'b1, 1'b0, 3, 1'b0};
        vecs[4] = '{0,  16'b0,                1'b0, 1'b0, 0, 1'b0};
        vecs[5] = '{6,  16'b111111,           1'b1, 1'b0, 0, 1'b0};
        vecs[6] = '{7,  16'b1010010,          1'b0, 1'b0, 1, 1'b0};
        vecs[7] = '{5,  16'b10010,            1'b0, 1'b1, 1, 1'b0};

        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.win_len   = 8'd0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.ack       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
        chk("rst_det_clr", 32'(bus.det_clr), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            if (i != 7) run_window(vecs[i]);
        end

        // Reset in the middle of a window: two of five bits accepted, then rst drops.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.win_len = 8'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bit_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mid_run_ready", 32'(bus.bit_ready), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_bit_ready", 32'(bus.bit_ready), 32'd0);
        chk("async_det_en", 32'(bus.det_en), 32'd0);
        chk("async_det_clr", 32'(bus.det_clr), 32'd0);
        chk("async_done", 32'(bus.done), 32'd0);
        chk("async_hit_cnt", 32'(bus.hit_cnt), 32'd0);
        chk("async_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        bus.bit_valid = 1'b0;
        rst = 1'b1;
        run_window(vecs[0]);

        // start and ack toggled while RUN is active must not disturb the window.
        run_window(vecs[7]);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
